div_sched: RTL and testbench

- Shares one fixed-point `divider` instance between NREQ requesters using round-robin arbitration.
- For each accepted request it latches the operands and forms dividend = {a, N zeros}, divisor = b.
- It drives the divider's en/dividend/divisor, waits for divider_ok, and returns the M-bit quotient to the owning requester.
- It sits between client datapaths and the single shared divider.

---
 rtl/div_sched_pkg.sv | 9 +
 rtl/div_sched_rr_arbiter.sv | 23 ++
 rtl/div_sched.sv | 108 ++++++++++
 tb/tb_div_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared widths, FSM encoding and fixed result codes for div_sched.
package div_sched_pkg;
  localparam int AW = 12;
  localparam int N = 14;
  localparam int M = AW + N;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_e;
  localparam logic [M-1:0] DZ_QUOTIENT = '1;
  localparam logic [M-1:0] ERR_QUOTIENT = '0;
endpackage

// File: rtl/div_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NREQ]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one fixed-point divider among NREQ requesters.
// Optional RUN-state abort after TIMEOUT cycles when DIV_SCHED_TIMEOUT_EN is defined.
module div_sched #(
  parameter int NREQ = 2,
  parameter int AW = div_sched_pkg::AW,
  parameter int N = div_sched_pkg::N,
  parameter int M = AW + N,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*AW-1:0] a_in_i,
  input  logic [NREQ*N-1:0] b_in_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [M-1:0]      rsp_quotient_o,
  output logic              rsp_dz_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              div_en_o,
  output logic [M-1:0]      div_dividend_o,
  output logic [N-1:0]      div_divisor_o,
  input  logic [M-1:0]      div_quotient_i,
  input  logic              div_ok_i
);
  import div_sched_pkg::*;
  localparam int IW = $clog2(NREQ);
  state_e          state_q;
  logic [IW-1:0]   ptr_q, own_q, idx;
  logic [NREQ-1:0] pick;
  logic [AW-1:0]   a_q, a_sel;
  logic [N-1:0]    b_q, b_sel;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req_i(req_i), .ptr_i(ptr_q), .gnt_o(pick), .idx_o(idx));
  assign a_sel = a_in_i[int'(idx) * AW +: AW];
  assign b_sel = b_in_i[int'(idx) * N +: N];
  assign busy_o = state_q != IDLE;
  assign div_dividend_o = {a_q, {N{1'b0}}};
  assign div_divisor_o = b_q;
`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
`else
  assign rsp_err_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      a_q <= '0;
      b_q <= '0;
      gnt_o <= '0;
      rsp_valid_o <= '0;
      rsp_quotient_o <= ERR_QUOTIENT;
      rsp_dz_o <= 1'b0;
      div_en_o <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
      rsp_err_o <= 1'b0;
      cnt_q <= '0;
`endif
    end else begin
      gnt_o <= '0;
      rsp_valid_o <= '0;
      rsp_dz_o <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
      rsp_err_o <= 1'b0;
`endif
      case (state_q)
        IDLE: if (|req_i) begin
          a_q <= a_sel;
          b_q <= b_sel;
          own_q <= idx;
          gnt_o <= pick;
          ptr_q <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
          // A zero divisor is answered immediately without touching the divider.
          if (b_sel == '0) begin
            rsp_valid_o <= pick;
            rsp_dz_o <= 1'b1;
            rsp_quotient_o <= DZ_QUOTIENT;
            state_q <= GAP;
          end else begin
            div_en_o <= 1'b1;
            state_q <= RUN;
`ifdef DIV_SCHED_TIMEOUT_EN
            cnt_q <= '0;
`endif
          end
        end
        RUN: if (div_ok_i) begin
          rsp_quotient_o <= div_quotient_i;
          rsp_valid_o <= NREQ'(1) << own_q;
          div_en_o <= 1'b0;
          state_q <= GAP;
        end
`ifdef DIV_SCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_quotient_o <= ERR_QUOTIENT;
          rsp_valid_o <= NREQ'(1) << own_q;
          rsp_err_o <= 1'b1;
          div_en_o <= 1'b0;
          state_q <= GAP;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed scoreboard bench for div_sched against a fixed-latency divider model.
module tb_div_sched;
  localparam int NREQ = 2, AW = 12, N = 14, M = 26, L = 8;
  typedef struct {int owner; logic [M-1:0] q; logic dz; logic err;} exp_t;
  logic clk = 1'b0, rst_n, inj = 1'b0, stuck = 1'b0, busy_prev = 1'b0;
  logic [NREQ-1:0] req, gnt, rsp_valid;
  logic [NREQ*AW-1:0] a_in;
  logic [NREQ*N-1:0] b_in;
  logic [M-1:0] rsp_quotient, div_dividend, div_quotient;
  logic [N-1:0] div_divisor;
  logic rsp_dz, rsp_err, busy, div_en, div_ok, ok_m;
  int dcnt, vectors = 0, errors = 0, cyc = 0, last_gnt = 0, last_rsp = 0;
  exp_t exp_q[$];
  exp_t e;
  int gnt_q[$];
  int gnt_t[$];

  div_sched dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .a_in_i(a_in), .b_in_i(b_in),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_quotient_o(rsp_quotient),
    .rsp_dz_o(rsp_dz), .rsp_err_o(rsp_err), .busy_o(busy), .div_en_o(div_en),
    .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_quotient_i(div_quotient), .div_ok_i(div_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Divider model: div_ok pulses L cycles after en rises, unless stuck.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dcnt <= 0;
      ok_m <= 1'b0;
      div_quotient <= '0;
    end else if (!div_en) begin
      dcnt <= 0;
      ok_m <= 1'b0;
    end else begin
      dcnt <= dcnt + 1;
      ok_m <= !stuck && (dcnt + 1 == L);
      if (dcnt + 1 == L) div_quotient <= div_dividend / M'(div_divisor);
    end
  assign div_ok = ok_m | inj;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M-1:0] qmod(logic [AW-1:0] a, logic [N-1:0] b);
    return {a, {N{1'b0}}} / M'(b);
  endfunction

  task automatic set_op(int i, logic [AW-1:0] a, logic [N-1:0] b);
    a_in[i*AW +: AW] = a;
    b_in[i*N +: N] = b;
  endtask

  task automatic expect_op(int i, logic [M-1:0] q, logic dz, logic err);
    exp_t x;
    x.owner = i;
    x.q = q;
    x.dz = dz;
    x.err = err;
    gnt_q.push_back(i);
    exp_q.push_back(x);
  endtask

  task automatic wait_grants(int n, string tag);
    int c = 0;
    while (gnt_t.size() < n && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk(tag, 64'(gnt_t.size() >= n), 1);
  endtask

  task automatic wait_done(string tag);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk(tag, {exp_q.size() == 0, busy}, 2'b10);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 0) begin
        chk("gnt_in_busy", busy_prev, 0);
        if (gnt_q.size() == 0) chk("gnt_unexp", gnt, 0);
        else chk("gnt_owner", gnt, 64'(1) << gnt_q.pop_front());
        gnt_t.push_back(cyc);
        last_gnt = cyc;
      end
      if (rsp_valid != 0) begin
        last_rsp = cyc;
        chk("rsp_dz_err_excl", rsp_dz & rsp_err, 0);
        if (exp_q.size() == 0) chk("rsp_unexp", rsp_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_owner", rsp_valid, 64'(1) << e.owner);
          chk("rsp_quotient", rsp_quotient, e.q);
          chk("rsp_dz", rsp_dz, e.dz);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
    busy_prev = busy;
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_div_en", div_en, 0);
    chk("rst_quotient", rsp_quotient, 0);
    chk("rst_dividend", div_dividend, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // single operation with the documented operands
    set_op(0, 12'h9D6, 14'h2D4B);
    expect_op(0, 26'h0000DE5, 1'b0, 1'b0);
    req = 2'b01;
    wait_grants(1, "single_gnt_wait");
    chk("single_dividend", div_dividend, 26'h2758000);
    chk("single_divisor", div_divisor, 14'h2D4B);
    chk("single_div_en", div_en, 1);
    req = '0;
    wait_done("single_done");
    chk("single_latency", last_rsp - last_gnt, L + 1);
    // divide by zero never enables the divider
    set_op(1, 12'h123, 14'h0000);
    expect_op(1, 26'h3FFFFFF, 1'b1, 1'b0);
    req = 2'b10;
    wait_grants(2, "dz_gnt_wait");
    req = '0;
    for (int i = 0; i < 3; i++) begin
      chk("dz_div_en", div_en, 0);
      @(posedge clk); #1;
    end
    wait_done("dz_done");
    // both held: grants alternate 0,1,0 at divider latency + 3
    set_op(0, 12'h100, 14'h0100);
    set_op(1, 12'h200, 14'h0100);
    expect_op(0, 26'h0004000, 1'b0, 1'b0);
    expect_op(1, 26'h0008000, 1'b0, 1'b0);
    expect_op(0, 26'h0004000, 1'b0, 1'b0);
    req = 2'b11;
    wait_grants(5, "rr_gnt_wait");
    req = '0;
    wait_done("rr_done");
    chk("rr_period_a", gnt_t[3] - gnt_t[2], L + 3);
    chk("rr_period_b", gnt_t[4] - gnt_t[3], L + 3);
    // stray div_ok in IDLE must be ignored
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_ok_busy", busy, 0);
    // reset five cycles into RUN discards the operation
    set_op(0, 12'h0AB, 14'h0013);
    gnt_q.push_back(0);
    req = 2'b01;
    wait_grants(6, "abort_gnt_wait");
    req = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_en", div_en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_div_en", div_en, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_op(1, 12'hFFF, 14'h0003);
    expect_op(1, qmod(12'hFFF, 14'h0003), 1'b0, 1'b0);
    req = 2'b10;
    wait_grants(7, "post_rst_gnt_wait");
    req = '0;
    wait_done("post_rst_done");
`ifdef DIV_SCHED_TIMEOUT_EN
    stuck = 1'b1;
    set_op(0, 12'h001, 14'h0001);
    expect_op(0, 26'h0, 1'b0, 1'b1);
    req = 2'b01;
    wait_grants(8, "tmo_gnt_wait");
    req = '0;
    wait_done("tmo_done");
    chk("tmo_latency", last_rsp - last_gnt, 64);
    stuck = 1'b0;
`endif
    chk("scoreboard_empty", exp_q.size() + gnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
